phase_sequencer: RTL and testbench

Multicycle controller for the non-pipelined LEGv8 core. It steps the fetch, decode/register-read, execute, memory and writeback resources one phase at a time, emitting one-hot phase strobes in place of the free-running read/write clocks. Memory phases are skipped for non-memory instructions and writeback is skipped when the instruction does not write a register. It handles instruction and data memory wait handshakes, single-step mode, halt, and a data-memory timeout.

---
 rtl/phase_sequencer_pkg.sv | 28 ++
 rtl/phase_sequencer_wait_timer.sv | 31 +++
 rtl/phase_sequencer.sv | 139 +++++++++++++
 tb/tb_phase_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared types for the multicycle phase sequencer.
// Holds the state encoding, strobe bundle and wait-counter width.
package phase_sequencer_pkg;

    localparam int SEQ_STATE_W = 3;
    localparam int WAIT_W      = 8;

    typedef enum logic [SEQ_STATE_W-1:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_FETCH     = 3'd1,
        SEQ_DECODE    = 3'd2,
        SEQ_EXECUTE   = 3'd3,
        SEQ_MEMORY    = 3'd4,
        SEQ_WRITEBACK = 3'd5,
        SEQ_HALTED    = 3'd6,
        SEQ_ILLEGAL   = 3'd7
    } seq_state_t;

    typedef struct packed {
        logic fetch;
        logic read;
        logic exec;
        logic mem;
        logic wb;
        logic pc;
    } strobe_t;

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// Data-memory wait counter: counts cycles spent in MEMORY.
// Ports: clk, rst_n, clr (hold at zero), en (count), expire (count == LIMIT-1).
module wait_timer
    import phase_sequencer_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(LIMIT - 1);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LAST) begin
            count <= count + WAIT_W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/phase_sequencer.sv
// Multicycle phase sequencer for the non-pipelined LEGv8 core.
// Inputs: start/step_mode, imem/dmem ready, decoded halt and control bits.
// Outputs: one-hot phase strobes, pc_en, busy/halted, sticky timeout,
//          saturating retired-instruction counter and debug state.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step_mode,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               halt_instr,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               reg_write,
    output logic               fetch_en,
    output logic               read_en,
    output logic               exec_en,
    output logic               mem_en,
    output logic               wb_en,
    output logic               pc_en,
    output logic               busy,
    output logic               halted,
    output logic               timeout_err,
    output logic [COUNT_W-1:0] retired_count,
    output logic [2:0]         state_o
);

    seq_state_t         state;
    seq_state_t         next;
    strobe_t            st;
    logic               fault;
    logic               expire;
    logic               in_mem;
    logic [COUNT_W-1:0] count;
    seq_state_t         target;

    assign in_mem = (state == SEQ_MEMORY);

    wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!in_mem),
        .en     (in_mem),
        .expire (expire)
    );

    // Where a retiring instruction hands over to.
    assign target = step_mode ? SEQ_IDLE : SEQ_FETCH;

    always_comb begin
        next  = state;
        st    = '0;
        fault = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (start) next = SEQ_FETCH;
            end
            SEQ_FETCH: begin
                st.fetch = 1'b1;
                if (imem_ready) next = SEQ_DECODE;
            end
            SEQ_DECODE: begin
                st.read = 1'b1;
                next    = halt_instr ? SEQ_HALTED : SEQ_EXECUTE;
            end
            SEQ_EXECUTE: begin
                st.exec = 1'b1;
                if (mem_read || mem_write) begin
                    next = SEQ_MEMORY;
                end else if (reg_write) begin
                    next = SEQ_WRITEBACK;
                end else begin
                    st.pc = 1'b1;
                    next  = target;
                end
            end
            SEQ_MEMORY: begin
                st.mem = 1'b1;
                // A completion on the expiry cycle beats the timeout.
                if (dmem_ready) begin
                    if (mem_read && reg_write) begin
                        next = SEQ_WRITEBACK;
                    end else begin
                        st.pc = 1'b1;
                        next  = target;
                    end
                end else if (expire) begin
                    fault = 1'b1;
                    next  = SEQ_HALTED;
                end
            end
            SEQ_WRITEBACK: begin
                st.wb = reg_write;
                st.pc = 1'b1;
                next  = target;
            end
            SEQ_HALTED: begin
                next = SEQ_HALTED;
            end
            default: begin
                next = SEQ_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEQ_IDLE;
            timeout_err <= 1'b0;
            count       <= '0;
        end else begin
            state <= next;
            if (fault) timeout_err <= 1'b1;
            if (st.pc && count != '1) begin
                count <= count + COUNT_W'(1);
            end
        end
    end

    assign fetch_en      = st.fetch;
    assign read_en       = st.read;
    assign exec_en       = st.exec;
    assign mem_en        = st.mem;
    assign wb_en         = st.wb;
    assign pc_en         = st.pc;
    assign busy          = (state != SEQ_IDLE) && (state != SEQ_HALTED);
    assign halted        = (state == SEQ_HALTED);
    assign retired_count = count;
    assign state_o       = state;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer.
// Per-cycle expectation records are built from instruction-level rules.
module tb_phase_sequencer;
    import phase_sequencer_pkg::*;

    localparam int TMO  = 16;
    localparam int SATW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, step_mode = 1'b0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0, halt_instr = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;

    logic fetch_en, read_en, exec_en, mem_en, wb_en, pc_en;
    logic busy, halted, timeout_err;
    logic [31:0] retired_count;
    logic [2:0]  state_o;

    logic s_fetch, s_read, s_exec, s_mem, s_wb, s_pc;
    logic s_busy, s_halted, s_tmo;
    logic [SATW-1:0] s_count;
    logic [2:0]      s_state;

    phase_sequencer #(.MEM_TIMEOUT(TMO), .COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .halt_instr(halt_instr), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write),
        .fetch_en(fetch_en), .read_en(read_en), .exec_en(exec_en),
        .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en), .busy(busy),
        .halted(halted), .timeout_err(timeout_err),
        .retired_count(retired_count), .state_o(state_o)
    );

    // Narrow counter copy: shows saturation without millions of cycles.
    phase_sequencer #(.MEM_TIMEOUT(TMO), .COUNT_W(SATW)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .halt_instr(halt_instr), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write),
        .fetch_en(s_fetch), .read_en(s_read), .exec_en(s_exec),
        .mem_en(s_mem), .wb_en(s_wb), .pc_en(s_pc), .busy(s_busy),
        .halted(s_halted), .timeout_err(s_tmo),
        .retired_count(s_count), .state_o(s_state)
    );

    always #5 clk = ~clk;

    // in = {start, imem, dmem, halt, mr, mw, rw, step}
    // exp = {fetch, read, exec, mem, wb, pc}
    typedef struct {
        logic [7:0] in;
        logic [5:0] exp;
        logic       busy;
        logic       hlt;
    } vec_t;

    vec_t q[$];
    vec_t add_tbl[5];
    int   total = 0;
    int   bad = 0;
    int   exp_count = 0;

    function automatic vec_t mk(input logic [7:0] in, input logic [5:0] e,
                                input logic b, input logic h);
        vec_t v;
        v.in   = in;
        v.exp  = e;
        v.busy = b;
        v.hlt  = h;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        {start, imem_ready, dmem_ready, halt_instr,
         mem_read, mem_write, reg_write, step_mode} = v.in;
        #1;
        check({nm, ".strobes"},
              32'({fetch_en, read_en, exec_en, mem_en, wb_en, pc_en}),
              32'(v.exp));
        check({nm, ".busy"}, 32'(busy), 32'(v.busy));
        check({nm, ".halted"}, 32'(halted), 32'(v.hlt));
    endtask

    task automatic run_q(input string nm);
        foreach (q[i]) apply(q[i], nm);
        q.delete();
    endtask

    // Let the last record's edge happen, then idle the inputs.
    task automatic settle();
        @(posedge clk);
        #1;
        {start, imem_ready, dmem_ready, halt_instr,
         mem_read, mem_write, reg_write, step_mode} = '0;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {start, imem_ready, dmem_ready, halt_instr,
         mem_read, mem_write, reg_write, step_mode} = '0;
        exp_count = 0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_start(input int n);
        for (int i = 0; i < n; i++) q.push_back(mk(8'h00, 6'b0, 1'b0, 1'b0));
        q.push_back(mk(8'h80, 6'b0, 1'b0, 1'b0));
    endtask

    // One instruction from the first FETCH cycle to its retire cycle.
    task automatic push_instr(input logic mr, mw, rw, input int iw, dw,
                              input logic sm);
        logic       mem;
        logic [5:0] e;
        logic [3:0] c;
        mem = mr | mw;
        c = {mr, mw, rw, sm};
        for (int i = 0; i < iw; i++)
            q.push_back(mk({4'b0000, c}, 6'b100000, 1'b1, 1'b0));
        q.push_back(mk({4'b0100, c}, 6'b100000, 1'b1, 1'b0));
        q.push_back(mk({4'b0000, c}, 6'b010000, 1'b1, 1'b0));
        e = 6'b001000;
        if (!mem && !rw) e[0] = 1'b1;
        q.push_back(mk({4'b0000, c}, e, 1'b1, 1'b0));
        if (mem) begin
            for (int i = 0; i < dw; i++)
                q.push_back(mk({4'b0000, c}, 6'b000100, 1'b1, 1'b0));
            e = 6'b000100;
            if (!(mr && rw)) e[0] = 1'b1;
            q.push_back(mk({4'b0010, c}, e, 1'b1, 1'b0));
        end
        if ((mem && mr && rw) || (!mem && rw))
            q.push_back(mk({4'b0000, c}, 6'b000011, 1'b1, 1'b0));
        exp_count++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic mr, mw, rw, sm;
        int   iw, dw;

        // Reset state.
        #12;
        check("rst.strobes",
              32'({fetch_en, read_en, exec_en, mem_en, wb_en, pc_en}), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.halted", 32'(halted), 0);
        check("rst.timeout", 32'(timeout_err), 0);
        check("rst.count", retired_count, 0);
        check("rst.state", 32'(state_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD: start, fetch, read, exec, wb+pc.
        add_tbl[0] = mk(8'b1000_0010, 6'b000000, 1'b0, 1'b0);
        add_tbl[1] = mk(8'b0100_0010, 6'b100000, 1'b1, 1'b0);
        add_tbl[2] = mk(8'b0000_0010, 6'b010000, 1'b1, 1'b0);
        add_tbl[3] = mk(8'b0000_0010, 6'b001000, 1'b1, 1'b0);
        add_tbl[4] = mk(8'b0000_0010, 6'b000011, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) apply(add_tbl[i], "add");
        exp_count = 1;
        settle();
        check("add.count", retired_count, 32'(exp_count));
        check("add.state", 32'(state_o), 1);

        // LDUR with 3 data wait cycles.
        push_instr(1'b1, 1'b0, 1'b1, 0, 3, 1'b0);
        run_q("ldur");
        settle();
        check("ldur.count", retired_count, 32'(exp_count));
        check("ldur.timeout", 32'(timeout_err), 0);

        // STUR completing on the very last allowed cycle.
        push_instr(1'b0, 1'b1, 1'b0, 0, TMO - 1, 1'b0);
        run_q("stur_edge");
        settle();
        check("edge.timeout", 32'(timeout_err), 0);
        check("edge.halted", 32'(halted), 0);
        check("edge.count", retired_count, 32'(exp_count));

        // Single-step: two CBZ-like instructions, IDLE between them.
        push_instr(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        push_start(2);
        push_instr(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        run_q("step");
        settle();
        check("step.state", 32'(state_o), 0);
        check("step.busy", 32'(busy), 0);
        check("step.count", retired_count, 32'(exp_count));

        // Random instruction mix.
        push_start(1);
        for (int n = 0; n < 60; n++) begin
            mr = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            iw = int'($urandom_range(0, 2));
            dw = ($urandom_range(0, 7) == 0) ? TMO - 1
                                             : int'($urandom_range(0, 3));
            sm = ($urandom_range(0, 3) == 0);
            push_instr(mr, mw, rw, iw, dw, sm);
            if (sm) push_start(int'($urandom_range(0, 2)));
        end
        run_q("rand");
        settle();
        check("rand.count", retired_count, 32'(exp_count));
        check("rand.sat_count", 32'(s_count),
              32'((exp_count > 7) ? 7 : exp_count));
        check("rand.timeout", 32'(timeout_err), 0);

        // One more retire on a saturated narrow counter.
        push_instr(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        run_q("sat");
        settle();
        check("sat.count", 32'(s_count), 7);
        check("sat.wide_count", retired_count, 32'(exp_count));

        // HALT after three instructions; start afterwards is ignored.
        do_reset();
        push_start(0);
        push_instr(1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
        push_instr(1'b1, 1'b0, 1'b1, 0, 1, 1'b0);
        push_instr(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        q.push_back(mk(8'b0100_0000, 6'b100000, 1'b1, 1'b0));
        q.push_back(mk(8'b0001_0000, 6'b010000, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            q.push_back(mk(8'b1000_0000, 6'b000000, 1'b0, 1'b1));
        run_q("halt");
        check("halt.count", retired_count, 3);
        check("halt.state", 32'(state_o), 6);
        check("halt.timeout", 32'(timeout_err), 0);

        // STUR that never completes: timeout after TMO MEMORY cycles.
        do_reset();
        push_start(0);
        q.push_back(mk(8'b0100_0100, 6'b100000, 1'b1, 1'b0));
        q.push_back(mk(8'b0000_0100, 6'b010000, 1'b1, 1'b0));
        q.push_back(mk(8'b0000_0100, 6'b001000, 1'b1, 1'b0));
        for (int i = 0; i < TMO; i++)
            q.push_back(mk(8'b0000_0100, 6'b000100, 1'b1, 1'b0));
        q.push_back(mk(8'b1000_0100, 6'b000000, 1'b0, 1'b1));
        q.push_back(mk(8'b1000_0100, 6'b000000, 1'b0, 1'b1));
        run_q("tmo");
        check("tmo.timeout", 32'(timeout_err), 1);
        check("tmo.count", retired_count, 0);
        check("tmo.state", 32'(state_o), 6);

        // Asynchronous reset in the middle of a LDUR's MEMORY phase.
        do_reset();
        push_start(0);
        push_instr(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        push_instr(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        q.push_back(mk(8'b0100_1010, 6'b100000, 1'b1, 1'b0));
        q.push_back(mk(8'b0000_1010, 6'b010000, 1'b1, 1'b0));
        q.push_back(mk(8'b0000_1010, 6'b001000, 1'b1, 1'b0));
        q.push_back(mk(8'b0000_1010, 6'b000100, 1'b1, 1'b0));
        q.push_back(mk(8'b0000_1010, 6'b000100, 1'b1, 1'b0));
        run_q("midrst");
        @(posedge clk);
        #2;
        check("midrst.pre_count", retired_count, 2);
        check("midrst.pre_state", 32'(state_o), 4);
        rst_n = 1'b0;
        #1;
        check("midrst.strobes",
              32'({fetch_en, read_en, exec_en, mem_en, wb_en, pc_en}), 0);
        check("midrst.busy", 32'(busy), 0);
        check("midrst.count", retired_count, 0);
        check("midrst.state", 32'(state_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_read = 1'b0;
        reg_write = 1'b0;
        @(negedge clk);
        #1;
        check("midrst.post_state", 32'(state_o), 0);
        check("midrst.post_count", retired_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
